// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state/op encodings and default widths for the
// arbitrated Booth sequential multiplier.
package seq_mult_pkg;

    localparam int DEF_N    = 32;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Booth recoding of {Q[0], q-1}
    typedef enum logic [1:0] {
        BOOTH_NOP0 = 2'b00,
        BOOTH_ADD  = 2'b01,
        BOOTH_SUB  = 2'b10,
        BOOTH_NOP1 = 2'b11
    } booth_op_e;

endpackage

// File: rtl/booth_seq_core.sv
// booth_seq_core: radix-2 Booth sequential multiplier datapath (A/Q/q-1 registers
// and one add/sub + arithmetic-shift step per cycle while step is high).
module booth_seq_core
    import seq_mult_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           step,
    output logic [2*N-1:0] product
);

    // One guard bit on A and M so that A - M with M = -2^(N-1) cannot wrap.
    logic signed [N:0] acc_q, acc_d;
    logic signed [N:0] m_q, m_d;
    logic signed [N:0] sum;
    logic [N-1:0]      q_q, q_d;
    logic              qm1_q, qm1_d;
    booth_op_e         op;

    always_comb begin
        acc_d = acc_q;
        q_d   = q_q;
        qm1_d = qm1_q;
        m_d   = m_q;
        sum   = acc_q;
        op    = booth_op_e'({q_q[0], qm1_q});
        if (load) begin
            acc_d = '0;
            q_d   = b;
            qm1_d = 1'b0;
            m_d   = {a[N-1], a};
        end else if (step) begin
            case (op)
                BOOTH_ADD: sum = acc_q + m_q;
                BOOTH_SUB: sum = acc_q - m_q;
                default:   sum = acc_q;
            endcase
            {acc_d, q_d, qm1_d} = {sum[N], sum, q_q};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            q_q   <= '0;
            qm1_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
            qm1_q <= qm1_d;
        end
    end

    always_ff @(posedge clk) begin
        m_q <= m_d;
    end

    assign product = {acc_q[N-1:0], q_q};

endmodule

// File: rtl/seq_mult_arbiter.sv
// seq_mult_arbiter: shares one Booth sequential multiplier among NREQ requesters.
// Define SEQ_MULT_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module seq_mult_arbiter
    import seq_mult_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*N-1:0]    rsp_product,
    output logic              busy
);

    localparam int CNTW = $clog2(N + 1);

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] grant_oh;
    logic [N-1:0]    grant_a, grant_b;
    logic            core_load, core_step;
`ifndef SEQ_MULT_FIXED_PRIO_EN
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
`endif

`ifdef SEQ_MULT_FIXED_PRIO_EN
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(i);
            end
        end
    end
`else
    // Scan downward so the last hit is the first requester at or after rr_ptr.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end
`endif

    assign grant_a = req_a[int'(grant_id)*N +: N];
    assign grant_b = req_b[int'(grant_id)*N +: N];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        grant_oh  = '0;
        core_load = 1'b0;
        core_step = 1'b0;
`ifndef SEQ_MULT_FIXED_PRIO_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    grant_oh[grant_id] = 1'b1;
                    core_load          = 1'b1;
                    id_d               = grant_id;
                    cnt_d              = '0;
                    state_d            = RUN;
                end
            end
            RUN: begin
                core_step = 1'b1;
                cnt_d     = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(N - 1)) state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
`ifndef SEQ_MULT_FIXED_PRIO_EN
                    rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            id_q     <= '0;
`ifndef SEQ_MULT_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
`ifndef SEQ_MULT_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    booth_seq_core #(.N(N)) u_core (
        .clk     (clk),
        .reset   (reset),
        .load    (core_load),
        .a       (grant_a),
        .b       (grant_b),
        .step    (core_step),
        .product (rsp_product)
    );

    // Gate with reset so no grant is visible while reset is held.
    assign req_ready = grant_oh & {NREQ{reset}};
    assign rsp_valid = (state_q == DONE);
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_mult_arbiter.sv
// tb_seq_mult_arbiter: randomized self-checking bench for seq_mult_arbiter against
// a behavioural model (signed multiply, cyclic first-valid arbitration).
module tb_seq_mult_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [2*N-1:0]    rsp_product;
    logic              busy;

    int checks   = 0;
    int errors   = 0;
    int rr_model = 0;

    always #5 clk = ~clk;

    seq_mult_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    function automatic longint ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        longint x, y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        return x * y;
    endfunction

    function automatic int ref_pick(input logic [NREQ-1:0] v, input int ptr);
`ifdef SEQ_MULT_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 0; k < NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`endif
        return -1;
    endfunction

    function automatic int next_rr(input int ptr, input int id);
`ifdef SEQ_MULT_FIXED_PRIO_EN
        return ptr;
`else
        return (id + 1) % NREQ;
`endif
    endfunction

    task automatic set_ops(input int r, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[r*N +: N] = a;
        req_b[r*N +: N] = b;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        rr_model = 0;
    endtask

    // Drives one lone request through grant, multiply and handshake.
    task automatic run_one(input int r, input logic [N-1:0] a, input logic [N-1:0] b,
                           input bit chg, output int lat, output logic [2*N-1:0] prod,
                           output int id, output bit ok);
        int wait_c;
        ok = 1'b1; lat = 0; prod = '0; id = -1;
        @(negedge clk);
        set_ops(r, a, b);
        req_valid[r] = 1'b1;
        rsp_ready    = 1'b1;
        #1;
        wait_c = 0;
        while (req_ready[r] !== 1'b1 && wait_c < 20) begin
            @(negedge clk); #1; wait_c++;
        end
        if (req_ready[r] !== 1'b1) begin
            ok = 1'b0; req_valid[r] = 1'b0; return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[r] = 1'b0;
        if (chg) set_ops(r, ~a, b + 1);
        while (rsp_valid !== 1'b1 && lat < 3*N) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        if (rsp_valid !== 1'b1) begin
            ok = 1'b0; return;
        end
        prod = rsp_product;
        id   = int'(rsp_id);
        @(posedge clk);
        rr_model = next_rr(rr_model, id);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        req_a     = {$urandom, $urandom, $urandom, $urandom};
        req_b     = {$urandom, $urandom, $urandom, $urandom};
        #3;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if (rsp_product !== '0) begin errors++; $display("FAIL reset_rsp_product: got %h expected 0", rsp_product); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        reset     = 1'b1;
        rr_model  = 0;
    endtask

    task automatic test_single();
        int lat, id; logic [2*N-1:0] prod; bit ok;
        run_one(0, 32'd7, 32'd2, 1'b0, lat, prod, id, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: no response within budget"); end
        checks++; if (lat != N) begin errors++; $display("FAIL single_latency: got %0d expected %0d", lat, N); end
        checks++; if (prod !== 64'd14) begin errors++; $display("FAIL single_product: got %0d expected 14", $signed(prod)); end
        checks++; if (id != 0) begin errors++; $display("FAIL single_id: got %0d expected 0", id); end
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid); end
        checks++; if (rsp_product !== 64'd14) begin errors++; $display("FAIL single_hold: got %0d expected 14", $signed(rsp_product)); end
    endtask

    task automatic test_signed_corners();
        logic [N-1:0] ta [6];
        logic [N-1:0] tb [6];
        int lat, id; logic [2*N-1:0] prod; bit ok; longint exp;
        ta[0] = -32'sd7;          tb[0] = 32'sd3;
        ta[1] = 32'sd20;          tb[1] = -32'sd10;
        ta[2] = -32'sd2;          tb[2] = -32'sd2;
        ta[3] = 32'sd0;           tb[3] = -32'sd60;
        ta[4] = 32'h8000_0000;    tb[4] = 32'h8000_0000;
        ta[5] = 32'h8000_0000;    tb[5] = 32'sd1;
        for (int i = 0; i < 6; i++) begin
            exp = ref_mul(ta[i], tb[i]);
            run_one(1, ta[i], tb[i], 1'b0, lat, prod, id, ok);
            checks++; if (!ok || lat != N) begin errors++; $display("FAIL corner%0d_latency: got %0d ok=%0d expected %0d", i, lat, ok, N); end
            checks++; if (prod !== exp) begin errors++; $display("FAIL corner%0d_product: got %0d expected %0d", i, $signed(prod), exp); end
            checks++; if (id != 1) begin errors++; $display("FAIL corner%0d_id: got %0d expected 1", i, id); end
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] ca [NREQ];
        logic [N-1:0] cb [NREQ];
        int exp_id, wait_c;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            ca[i] = $urandom; cb[i] = $urandom;
            set_ops(i, ca[i], cb[i]);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            exp_id = ref_pick(req_valid, rr_model);
            checks++; if (req_ready !== (NREQ'(1) << exp_id)) begin errors++; $display("FAIL contend%0d_ready: got %b expected one-hot %0d", g, req_ready, exp_id); end
            wait_c = 0;
            while (rsp_valid !== 1'b1 && wait_c < 3*N) begin
                @(posedge clk); wait_c++; @(negedge clk);
            end
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL contend%0d_timeout: rsp_valid=%b expected 1", g, rsp_valid); end
            checks++; if (int'(rsp_id) != exp_id) begin errors++; $display("FAIL contend%0d_id: got %0d expected %0d", g, rsp_id, exp_id); end
            checks++; if (rsp_product !== ref_mul(ca[exp_id], cb[exp_id])) begin errors++; $display("FAIL contend%0d_product: got %0d expected %0d", g, $signed(rsp_product), ref_mul(ca[exp_id], cb[exp_id])); end
            @(posedge clk);
            rr_model = next_rr(rr_model, exp_id);
            @(negedge clk);
        end
        req_valid = '0;
        repeat (N + 3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [N-1:0] a, b; longint exp; int wait_c;
        a = $urandom; b = $urandom; exp = ref_mul(a, b);
        @(negedge clk);
        set_ops(2, a, b);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        wait_c = 0;
        while (req_ready[2] !== 1'b1 && wait_c < 20) begin @(negedge clk); #1; wait_c++; end
        checks++; if (req_ready[2] !== 1'b1) begin errors++; $display("FAIL bp_grant: req_ready=%b expected bit 2", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0001;
        wait_c = 0;
        while (rsp_valid !== 1'b1 && wait_c < 3*N) begin @(posedge clk); wait_c++; @(negedge clk); end
        for (int c = 0; c < 50; c++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d: got %b expected 1", c, rsp_valid); end
            checks++; if (rsp_product !== exp) begin errors++; $display("FAIL bp_product_c%0d: got %0d expected %0d", c, $signed(rsp_product), exp); end
            checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL bp_id_c%0d: got %0d expected 2", c, rsp_id); end
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_ready_c%0d: got %b expected 0", c, req_ready); end
            @(posedge clk); @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        rr_model = next_rr(rr_model, 2);
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy); end
        @(posedge clk); @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_once: rsp_valid=%b expected 0", rsp_valid); end
    endtask

    task automatic test_random();
        logic [N-1:0] a, b; int r, lat, id; logic [2*N-1:0] prod; bit ok; longint exp;
        logic [N-1:0] corner [4];
        corner[0] = 32'h8000_0000; corner[1] = 32'h7fff_ffff;
        corner[2] = 32'h0000_0000; corner[3] = 32'hffff_ffff;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, NREQ - 1);
            a = (i < 4) ? corner[i] : $urandom;
            b = (i < 4) ? corner[3 - i] : $urandom;
            if (i == 4) b = corner[1];
            exp = ref_mul(a, b);
            run_one(r, a, b, 1'b0, lat, prod, id, ok);
            checks++; if (!ok || lat != N) begin errors++; $display("FAIL rand%0d_latency: got %0d ok=%0d expected %0d", i, lat, ok, N); end
            checks++; if (prod !== exp) begin errors++; $display("FAIL rand%0d_product: a=%h b=%h got %0d expected %0d", i, a, b, $signed(prod), exp); end
            checks++; if (id != r) begin errors++; $display("FAIL rand%0d_id: got %0d expected %0d", i, id, r); end
        end
    endtask

    task automatic test_operand_change();
        logic [N-1:0] a, b; int lat, id; logic [2*N-1:0] prod; bit ok; longint exp;
        a = $urandom; b = $urandom; exp = ref_mul(a, b);
        run_one(3, a, b, 1'b1, lat, prod, id, ok);
        checks++; if (!ok || prod !== exp) begin errors++; $display("FAIL opchange_product: got %0d ok=%0d expected %0d", $signed(prod), ok, exp); end
        checks++; if (id != 3) begin errors++; $display("FAIL opchange_id: got %0d expected 3", id); end
    endtask

    task automatic test_reset_mid_run();
        int lat, id, wait_c; logic [2*N-1:0] prod; bit ok;
        @(negedge clk);
        set_ops(1, $urandom | 32'h0000_1000, $urandom | 32'h0001_0001);
        req_valid = 4'b0010;
        #1;
        wait_c = 0;
        while (req_ready[1] !== 1'b1 && wait_c < 20) begin @(negedge clk); #1; wait_c++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0100;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid); end
        checks++; if (rsp_product !== '0) begin errors++; $display("FAIL midrst_product: got %h expected 0", rsp_product); end
        checks++; if (rsp_id !== '0 || req_ready !== '0) begin errors++; $display("FAIL midrst_id_ready: id=%0d ready=%b expected 0 0", rsp_id, req_ready); end
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b1;
        rr_model  = 0;
        repeat (N + 4) @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_noresp: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy); end
        run_one(3, 32'sd5, -32'sd125, 1'b0, lat, prod, id, ok);
        checks++; if (!ok || lat != N) begin errors++; $display("FAIL midrst_new_latency: got %0d ok=%0d expected %0d", lat, ok, N); end
        checks++; if (prod !== 64'(-64'sd625)) begin errors++; $display("FAIL midrst_new_product: got %0d expected -625", $signed(prod)); end
        checks++; if (id != 3) begin errors++; $display("FAIL midrst_new_id: got %0d expected 3", id); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_signed_corners();
        test_contention();
        test_backpressure();
        test_random();
        test_operand_change();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
